// File: rtl/ddr3_dm_lane_tx_gen.sv
// ddr3_dm_lane_tx_gen: DM lane write-path generator for the DDR3 PHY IOD.
// Delays write-enable/mask by wr_lat and frames each burst with OE pre/postamble and ODT hold.
module ddr3_dm_lane_tx_gen #(
    parameter int   WL_MAX      = 16,
    parameter logic DM_IDLE_VAL = 1'b0,
    parameter int   ODT_HOLD    = 2
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic [3:0] wr_lat,
    input  logic       wrdata_en,
    input  logic [7:0] wrdata_mask,
    input  logic       dm_force_en,
    input  logic       dm_force_val,
    input  logic       err_clr,
    output logic [7:0] TX_DATA_0,
    output logic [3:0] OE_DATA_0,
    output logic       ODT_EN_0,
    output logic       busy,
    output logic       lat_err
);
    localparam int         CW        = $clog2(ODT_HOLD + 2);
    localparam logic [7:0] IDLE_BYTE = {8{DM_IDLE_VAL}};

    typedef enum logic [1:0] {IDLE, PRE, BURST, POST} state_t;
    typedef struct packed {
        logic       en;
        logic [7:0] mask;
    } beat_t;

    beat_t         dl_q [WL_MAX];
    beat_t         dl_d [WL_MAX];
    beat_t         early;
    state_t        state_q, state_d;
    logic [3:0]    lat_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q;
    logic [7:0]    mask_q;
    logic [7:0]    tx_q;
    logic [3:0]    oe_q;
    logic          odt_q, odt_d;
    logic          busy_q, busy_d;
    logic          err_q;
    logic          en_any;

    assign early = dl_q[lat_q];

    // Entries shifted past the active tap are dropped so busy falls as soon as the burst is consumed.
    always_comb begin
        dl_d[0].en   = wrdata_en;
        dl_d[0].mask = !wrdata_en ? 8'h00 : dm_force_en ? {8{dm_force_val}} : wrdata_mask;
        for (int i = 1; i < WL_MAX; i++) dl_d[i] = (i > int'(lat_q)) ? '0 : dl_q[i-1];
        en_any = 1'b0;
        for (int i = 0; i < WL_MAX; i++) en_any = en_any | dl_d[i].en;
    end

    // pend_q/mask_q hold the beat seen on the early tap one cycle before it is transmitted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = early.en ? PRE : IDLE;
            PRE:     state_d = BURST;
            BURST:   state_d = pend_q ? BURST : POST;
            default: state_d = pend_q ? BURST : (early.en ? PRE : IDLE);
        endcase
        cnt_d  = (state_d == POST) ? CW'(ODT_HOLD) :
                 (state_d == IDLE && cnt_q != '0) ? cnt_q - CW'(1) : '0;
        odt_d  = (state_d != IDLE) || (cnt_q != '0);
        busy_d = en_any || (state_d != IDLE) || odt_d;
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            for (int i = 0; i < WL_MAX; i++) dl_q[i] <= '0;
            state_q <= IDLE;
            lat_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            mask_q  <= '0;
            tx_q    <= IDLE_BYTE;
            oe_q    <= '0;
            odt_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            dl_q    <= dl_d;
            state_q <= state_d;
            lat_q   <= busy_q ? lat_q : wr_lat;
            err_q   <= (busy_q && wr_lat != lat_q) || (err_q && !err_clr);
            cnt_q   <= cnt_d;
            pend_q  <= early.en;
            mask_q  <= early.mask;
            tx_q    <= (state_d == BURST) ? mask_q : IDLE_BYTE;
            oe_q    <= (state_d != IDLE) ? 4'hF : 4'h0;
            odt_q   <= odt_d;
            busy_q  <= busy_d;
        end
    end

    assign TX_DATA_0 = tx_q;
    assign OE_DATA_0 = oe_q;
    assign ODT_EN_0  = odt_q;
    assign busy      = busy_q;
    assign lat_err   = err_q;
endmodule

// File: tb/tb_ddr3_dm_lane_tx_gen.sv
// tb_ddr3_dm_lane_tx_gen: directed bench for the DM lane write-path generator.
module tb_ddr3_dm_lane_tx_gen;
    logic       FAB_CLK = 1'b0;
    logic       ARST_N;
    logic [3:0] wr_lat;
    logic       wrdata_en;
    logic [7:0] wrdata_mask;
    logic       dm_force_en;
    logic       dm_force_val;
    logic       err_clr;
    logic [7:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic       ODT_EN_0;
    logic       busy;
    logic       lat_err;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 FAB_CLK = ~FAB_CLK;

    ddr3_dm_lane_tx_gen dut (
        .FAB_CLK     (FAB_CLK),
        .ARST_N      (ARST_N),
        .wr_lat      (wr_lat),
        .wrdata_en   (wrdata_en),
        .wrdata_mask (wrdata_mask),
        .dm_force_en (dm_force_en),
        .dm_force_val(dm_force_val),
        .err_clr     (err_clr),
        .TX_DATA_0   (TX_DATA_0),
        .OE_DATA_0   (OE_DATA_0),
        .ODT_EN_0    (ODT_EN_0),
        .busy        (busy),
        .lat_err     (lat_err)
    );

    task automatic step();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s@%0d: observed %h expected %h", tag, k, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k, input logic [7:0] tx, input logic [3:0] oe,
                           input logic odt);
        chk({tag, ".tx"}, k, TX_DATA_0, tx);
        chk({tag, ".oe"}, k, 8'(OE_DATA_0), 8'(oe));
        chk({tag, ".odt"}, k, 8'(ODT_EN_0), 8'(odt));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) step();
        chk("idle_timeout", 0, 8'(busy), 8'h00);
    endtask

    task automatic single_burst(input string tag);
        wr_lat      = 4'd3;
        wrdata_en   = 1'b1;
        wrdata_mask = 8'hA5;
        step();
        wrdata_en   = 1'b0;
        wrdata_mask = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_all(tag, k, (k == 5) ? 8'hA5 : 8'h00, (k >= 4 && k <= 6) ? 4'hF : 4'h0, k >= 4 && k <= 8);
            chk({tag, ".busy"}, k, 8'(busy), 8'(k <= 8));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        ARST_N = 1'b0; wr_lat = 4'd0; wrdata_en = 1'b0; wrdata_mask = 8'h00;
        dm_force_en = 1'b0; dm_force_val = 1'b0; err_clr = 1'b0;
        #2;
        chk_all("reset", 0, 8'h00, 4'h0, 1'b0);
        chk("reset.busy", 0, 8'(busy), 8'h00);
        chk("reset.err", 0, 8'(lat_err), 8'h00);
        step();
        step();
        ARST_N = 1'b1;
        step();

        single_burst("single");
        wait_idle();

        wr_lat = 4'd0;
        for (int k = 0; k < 8; k++) begin
            wrdata_en   = (k < 3);
            wrdata_mask = 8'(1 << k);
            step();
            chk_all("b2b", k, (k >= 2 && k <= 4) ? 8'(1 << (k - 2)) : 8'h00,
                    (k >= 1 && k <= 5) ? 4'hF : 4'h0, k >= 1 && k <= 7);
        end
        wait_idle();

        wr_lat = 4'd2;
        for (int k = 0; k < 10; k++) begin
            wrdata_en   = (k == 0 || k == 2);
            wrdata_mask = (k == 0) ? 8'hFF : (k == 2) ? 8'h0F : 8'h33;
            step();
            chk_all("gap", k, (k == 4) ? 8'hFF : (k == 6) ? 8'h0F : 8'h00,
                    (k >= 3 && k <= 7) ? 4'hF : 4'h0, k >= 3 && k <= 9);
        end
        wait_idle();

        wr_lat      = 4'd4;
        wrdata_en   = 1'b1;
        wrdata_mask = 8'h3C;
        step();
        wrdata_en   = 1'b0;
        wr_lat      = 4'd7;
        for (int k = 1; k <= 9; k++) begin
            err_clr = (k == 2);
            step();
            chk_all("laterr", k, (k == 6) ? 8'h3C : 8'h00, (k >= 5 && k <= 7) ? 4'hF : 4'h0, k >= 5 && k <= 9);
            chk("laterr.flag", k, 8'(lat_err), 8'h01);
        end
        err_clr = 1'b0;
        wait_idle();
        chk("laterr.sticky", 0, 8'(lat_err), 8'h01);
        err_clr = 1'b1;
        step();
        chk("laterr.clr", 0, 8'(lat_err), 8'h00);
        err_clr = 1'b0;

        wrdata_en   = 1'b1;
        wrdata_mask = 8'hC3;
        step();
        wrdata_en   = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_all("lat7", k, (k == 9) ? 8'hC3 : 8'h00, (k >= 8 && k <= 10) ? 4'hF : 4'h0, k >= 8 && k <= 12);
        end
        chk("lat7.err", 0, 8'(lat_err), 8'h00);
        wait_idle();

        wr_lat       = 4'd1;
        dm_force_en  = 1'b1;
        dm_force_val = 1'b1;
        wrdata_en    = 1'b1;
        wrdata_mask  = 8'h00;
        step();
        dm_force_en  = 1'b0;
        wrdata_en    = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk_all("force", k, (k == 3) ? 8'hFF : 8'h00, (k >= 2 && k <= 4) ? 4'hF : 4'h0, k >= 2 && k <= 6);
        end
        wait_idle();
        dm_force_val = 1'b0;

        wr_lat      = 4'd3;
        wrdata_en   = 1'b1;
        wrdata_mask = 8'h5A;
        step();
        wrdata_en   = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        chk("rst.burst", 5, TX_DATA_0, 8'h5A);
        #2;
        ARST_N = 1'b0;
        #1;
        chk_all("rst.async", 0, 8'h00, 4'h0, 1'b0);
        chk("rst.busy", 0, 8'(busy), 8'h00);
        chk("rst.err", 0, 8'(lat_err), 8'h00);
        step();
        step();
        ARST_N = 1'b1;
        step();
        chk_all("rst.nopost", 0, 8'h00, 4'h0, 1'b0);
        single_burst("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
